tennis_scoreboard: RTL and testbench

//  Sequential tennis scorekeeper for two players (A, B). Consumes single-cycle point pulses and

---
 rtl/tennis_scoreboard.sv | 221 ++++++++++++++++++++++
 tb/tb_tennis_scoreboard.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tennis_scoreboard.sv
// Two-player tennis scorekeeper: points, deuce/advantage, games, server and set winner.
// Latency: every output is registered; a point pulse is reflected one cycle later.
// Points are dropped while the game-won code is held and after the set is decided.
module tennis_scoreboard #(
  parameter int GAMES_TO_WIN = 6,
  parameter int GAME_W       = 4,
  parameter int HOLD_CYCLES  = 50,
  parameter int HOLD_W       = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              point_a,
  input  logic              point_b,
  output logic [7:0]        score_a,
  output logic [7:0]        score_b,
  output logic [GAME_W-1:0] games_a,
  output logic [GAME_W-1:0] games_b,
  output logic              server,
  output logic [1:0]        game_won,
  output logic [1:0]        set_winner,
  output logic              busy,
  output logic              conflict
);

  typedef enum logic [2:0] {PLAY, DEUCE, ADV_A, ADV_B, HOLD, SET_DONE} state_t;

  localparam logic [GAME_W-1:0] GMAX  = GAME_W'(GAMES_TO_WIN + 1);
  localparam logic [GAME_W-1:0] GWIN  = GAME_W'(GAMES_TO_WIN);
  localparam logic [GAME_W:0]   TWO   = (GAME_W + 1)'(2);
  localparam logic [HOLD_W-1:0] HLAST = HOLD_W'(HOLD_CYCLES - 1);

  localparam logic [7:0] C_LOVE = 8'hF0, C_15 = 8'h15, C_30 = 8'h30, C_40 = 8'h40;
  localparam logic [7:0] C_AD = 8'hAD, C_GAME = 8'hFA, C_BLANK = 8'hFE;

  state_t            state, state_n;
  logic [1:0]        pa, pb, pa_n, pb_n;
  logic [GAME_W-1:0] ga_n, gb_n;
  logic [HOLD_W-1:0] cnt, cnt_n;
  logic              win, win_n;      // 0 = A took the current game, 1 = B
  logic              srv_n, busy_n, cf_n;
  logic [1:0]        sw_n, gw_n;
  logic [7:0]        sa_n, sb_n;
  logic              ev_a, ev_b;

  function automatic logic [7:0] pt_code(input logic [1:0] p);
    case (p)
      2'd0:    return C_LOVE;
      2'd1:    return C_15;
      2'd2:    return C_30;
      default: return C_40;
    endcase
  endfunction

  // w = winner games, l = loser games, both already including the game just won
  function automatic logic set_won(input logic [GAME_W-1:0] w, input logic [GAME_W-1:0] l);
    return ((w >= GWIN) && ({1'b0, w} >= ({1'b0, l} + TWO))) || (w == GMAX);
  endfunction

  assign ev_a = point_a & ~point_b;
  assign ev_b = point_b & ~point_a;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PLAY;
    else        state <= state_n;
  end

  // Next-state, counters and pulses; a game win always passes through the HOLD entry here
  always_comb begin
    state_n = state;
    pa_n    = pa;
    pb_n    = pb;
    ga_n    = games_a;
    gb_n    = games_b;
    srv_n   = server;
    sw_n    = set_winner;
    win_n   = win;
    cnt_n   = cnt;
    gw_n    = 2'b00;
    cf_n    = 1'b0;
    case (state)
      PLAY: begin
        cf_n = point_a & point_b;
        if (ev_a) begin
          if (pa == 2'd3) begin
            state_n = HOLD;
            win_n   = 1'b0;
          end else begin
            pa_n = pa + 2'd1;
            if (pa == 2'd2 && pb == 2'd3) state_n = DEUCE;
          end
        end else if (ev_b) begin
          if (pb == 2'd3) begin
            state_n = HOLD;
            win_n   = 1'b1;
          end else begin
            pb_n = pb + 2'd1;
            if (pb == 2'd2 && pa == 2'd3) state_n = DEUCE;
          end
        end
      end
      DEUCE: begin
        cf_n = point_a & point_b;
        if (ev_a)      state_n = ADV_A;
        else if (ev_b) state_n = ADV_B;
      end
      ADV_A: begin
        cf_n = point_a & point_b;
        if (ev_a) begin
          state_n = HOLD;
          win_n   = 1'b0;
        end else if (ev_b) begin
          state_n = DEUCE;
        end
      end
      ADV_B: begin
        cf_n = point_a & point_b;
        if (ev_b) begin
          state_n = HOLD;
          win_n   = 1'b1;
        end else if (ev_a) begin
          state_n = DEUCE;
        end
      end
      HOLD: begin
        if (cnt == HLAST) begin
          if (win ? set_won(games_b, games_a) : set_won(games_a, games_b)) begin
            state_n = SET_DONE;
            sw_n    = win ? 2'b10 : 2'b01;
          end else begin
            state_n = PLAY;
            srv_n   = ~server;
            pa_n    = 2'd0;
            pb_n    = 2'd0;
          end
        end else begin
          cnt_n = cnt + HOLD_W'(1);
        end
      end
      default: ;  // SET_DONE: frozen until clear
    endcase

    // Entry into HOLD credits the game exactly once
    if (state != HOLD && state_n == HOLD) begin
      cnt_n = '0;
      if (win_n) begin
        gw_n = 2'b10;
        gb_n = (games_b == GMAX) ? games_b : games_b + GAME_W'(1);
      end else begin
        gw_n = 2'b01;
        ga_n = (games_a == GMAX) ? games_a : games_a + GAME_W'(1);
      end
    end

    if (clear) begin
      state_n = PLAY;
      pa_n    = 2'd0;
      pb_n    = 2'd0;
      ga_n    = '0;
      gb_n    = '0;
      srv_n   = 1'b0;
      sw_n    = 2'b00;
      win_n   = 1'b0;
      cnt_n   = '0;
      gw_n    = 2'b00;
      cf_n    = 1'b0;
    end
  end

  // Display decode from the next state so the registered codes track the state with no lag
  always_comb begin
    sa_n   = pt_code(pa_n);
    sb_n   = pt_code(pb_n);
    busy_n = (state_n == HOLD);
    case (state_n)
      DEUCE: begin sa_n = C_40; sb_n = C_40; end
      ADV_A: begin sa_n = C_AD; sb_n = C_40; end
      ADV_B: begin sa_n = C_40; sb_n = C_AD; end
      HOLD, SET_DONE: begin
        sa_n = win_n ? C_BLANK : C_GAME;
        sb_n = win_n ? C_GAME  : C_BLANK;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa         <= 2'd0;
      pb         <= 2'd0;
      games_a    <= '0;
      games_b    <= '0;
      server     <= 1'b0;
      set_winner <= 2'b00;
      win        <= 1'b0;
      cnt        <= '0;
      game_won   <= 2'b00;
      conflict   <= 1'b0;
      busy       <= 1'b0;
      score_a    <= C_LOVE;
      score_b    <= C_LOVE;
    end else begin
      pa         <= pa_n;
      pb         <= pb_n;
      games_a    <= ga_n;
      games_b    <= gb_n;
      server     <= srv_n;
      set_winner <= sw_n;
      win        <= win_n;
      cnt        <= cnt_n;
      game_won   <= gw_n;
      conflict   <= cf_n;
      busy       <= busy_n;
      score_a    <= sa_n;
      score_b    <= sb_n;
    end
  end

endmodule

// File: tb/tb_tennis_scoreboard.sv
// Directed bench for tennis_scoreboard with hand-computed expected values.
// Uses a short hold time so whole sets run quickly.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_tennis_scoreboard;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       point_a = 1'b0;
  logic       point_b = 1'b0;
  logic [7:0] score_a, score_b;
  logic [3:0] games_a, games_b;
  logic       server, busy, conflict;
  logic [1:0] game_won, set_winner;

  int total = 0;
  int bad   = 0;

  tennis_scoreboard #(.GAMES_TO_WIN(6), .GAME_W(4), .HOLD_CYCLES(H), .HOLD_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .point_a(point_a), .point_b(point_b),
    .score_a(score_a), .score_b(score_b), .games_a(games_a), .games_b(games_b),
    .server(server), .game_won(game_won), .set_winner(set_winner),
    .busy(busy), .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pt(input logic a, input logic b);
    point_a = a;
    point_b = b;
    step(1);
    point_a = 1'b0;
    point_b = 1'b0;
  endtask

  task automatic wait_hold;
    int n = 0;
    while (busy && n < 200) begin
      step(1);
      n++;
    end
    chk("hold_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic win_game(input logic b_wins);
    repeat (4) pt(~b_wins, b_wins);
    wait_hold();
  endtask

  task automatic chk_scores(input string tag, input logic [7:0] ea, input logic [7:0] eb);
    chk(tag, {16'd0, score_a, score_b}, {16'd0, ea, eb});
  endtask

  initial begin
    step(2);
    rst_n = 1'b1;
    step(1);

    // reset state
    chk_scores("rst_scores", 8'hF0, 8'hF0);
    chk("rst_games", {24'd0, games_a, games_b}, 32'h00);
    chk("rst_misc", {26'd0, server, set_winner, busy, game_won[0] | game_won[1], conflict},
        32'd0);

    // game 1: A four straight points, hold timing boundary
    pt(1, 0); chk_scores("a15", 8'h15, 8'hF0);
    pt(1, 0); chk_scores("a30", 8'h30, 8'hF0);
    pt(1, 0); chk_scores("a40", 8'h40, 8'hF0);
    pt(1, 0); chk_scores("a_game", 8'hFA, 8'hFE);
    chk("gw_pulse", {30'd0, game_won}, 32'd1);
    chk("g1_games", {24'd0, games_a, games_b}, 32'h10);
    chk("g1_busy", {31'd0, busy}, 32'd1);
    step(1);
    chk("gw_one_cycle", {30'd0, game_won}, 32'd0);
    pt(1, 0);
    chk_scores("busy_ignored", 8'hFA, 8'hFE);
    chk("busy_games", {24'd0, games_a, games_b}, 32'h10);
    step(H - 3);
    chk("hold_last", {31'd0, busy}, 32'd1);
    step(1);
    chk("hold_exit", {31'd0, busy}, 32'd0);
    chk_scores("g1_love", 8'hF0, 8'hF0);
    chk("g1_server", {31'd0, server}, 32'd1);

    // game 2: deuce and advantage
    for (int i = 0; i < 3; i++) begin
      pt(1, 0);
      pt(0, 1);
    end
    chk_scores("deuce", 8'h40, 8'h40);
    pt(1, 0); chk_scores("adv_a", 8'hAD, 8'h40);
    pt(0, 1); chk_scores("back_deuce", 8'h40, 8'h40);
    pt(0, 1); chk_scores("adv_b", 8'h40, 8'hAD);
    pt(1, 0); chk_scores("deuce2", 8'h40, 8'h40);
    pt(1, 0); chk_scores("adv_a2", 8'hAD, 8'h40);
    pt(1, 0); chk_scores("adv_game", 8'hFA, 8'hFE);
    chk("g2_games", {24'd0, games_a, games_b}, 32'h20);
    wait_hold();
    chk("g2_server", {31'd0, server}, 32'd0);

    // game 3: simultaneous points at 15/30
    pt(1, 0);
    pt(0, 1);
    pt(0, 1);
    chk_scores("pre_conf", 8'h15, 8'h30);
    pt(1, 1);
    chk("conf_pulse", {31'd0, conflict}, 32'd1);
    chk_scores("conf_scores", 8'h15, 8'h30);
    step(1);
    chk("conf_one_cycle", {31'd0, conflict}, 32'd0);
    pt(1, 0);
    pt(1, 0);
    pt(1, 0);
    chk("g3_games", {24'd0, games_a, games_b}, 32'h30);
    wait_hold();

    // games 4..6: A takes the set 6/0
    win_game(1'b0);
    win_game(1'b0);
    chk("g5_no_set", {30'd0, set_winner}, 32'd0);
    win_game(1'b0);
    chk("set_a", {30'd0, set_winner}, 32'd1);
    chk("set_games", {24'd0, games_a, games_b}, 32'h60);
    chk_scores("set_scores", 8'hFA, 8'hFE);
    pt(0, 1);
    pt(1, 0);
    chk_scores("set_frozen", 8'hFA, 8'hFE);
    chk("set_frozen_games", {24'd0, games_a, games_b}, 32'h60);
    chk("set_not_busy", {31'd0, busy}, 32'd0);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    chk_scores("clr_scores", 8'hF0, 8'hF0);
    chk("clr_state", {22'd0, games_a, games_b, set_winner, server}, 32'd0);

    // clear beats a same-cycle point
    pt(1, 0);
    chk_scores("pre_clr", 8'h15, 8'hF0);
    clear = 1'b1;
    point_a = 1'b1;
    step(1);
    clear = 1'b0;
    point_a = 1'b0;
    chk_scores("clr_vs_point", 8'hF0, 8'hF0);

    // 5/5 -> 6/5 -> 6/6 -> 7/6
    for (int i = 0; i < 5; i++) begin
      win_game(1'b0);
      win_game(1'b1);
    end
    chk("g55", {24'd0, games_a, games_b}, 32'h55);
    win_game(1'b0);
    chk("g65", {24'd0, games_a, games_b}, 32'h65);
    chk("g65_no_set", {30'd0, set_winner}, 32'd0);
    win_game(1'b1);
    chk("g66", {24'd0, games_a, games_b}, 32'h66);
    chk("g66_no_set", {30'd0, set_winner}, 32'd0);
    win_game(1'b0);
    chk("g76", {24'd0, games_a, games_b}, 32'h76);
    chk("g76_set", {30'd0, set_winner}, 32'd1);

    // asynchronous reset in the middle of HOLD
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    repeat (4) pt(0, 1);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_scores("arst_scores", 8'hF0, 8'hF0);
    chk("arst_state", {23'd0, games_a, games_b, busy, game_won}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    chk("post_rst", {22'd0, games_a, games_b, busy, game_won, server}, 32'd0);
    chk_scores("post_rst_scores", 8'hF0, 8'hF0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
